// File: rtl/pe_array_acc_pkg.sv
// Shared types and the saturating clamp used by every element of the PE array.
package pe_array_acc_pkg;

   typedef enum logic [1:0] {
      MODE_MUL  = 2'd0,
      MODE_ADD  = 2'd1,
      MODE_MAC  = 2'd2,
      MODE_BIAS = 2'd3
   } pe_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } burst_state_e;

   typedef enum logic [1:0] {
      BASE_ZERO = 2'd0,
      BASE_ACC  = 2'd1,
      BASE_IN   = 2'd2
   } base_sel_e;

   // Working width for pre-clamp sums; must exceed ACC_WIDTH and 2*DATA_WIDTH.
   localparam int SAT_W = 64;

   function automatic logic signed [SAT_W-1:0] sat_acc(input logic signed [SAT_W-1:0] v,
                                                       input int acc_w,
                                                       output logic ovf);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) <<< (acc_w - 1)) - SAT_W'(1);
      lo = ~hi;
      ovf = 1'b0;
      sat_acc = v;
      if (v > hi) begin
         sat_acc = hi;
         ovf = 1'b1;
      end else if (v < lo) begin
         sat_acc = lo;
         ovf = 1'b1;
      end
   endfunction

endpackage

// File: rtl/pe_array_acc_if.sv
// Operand-tile input stream and result-tile output stream of the PE array.
interface pe_array_acc_if
   import pe_array_acc_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int CNT_WIDTH  = 8
);
   logic                         in_valid;
   logic                         in_ready;
   pe_mode_e                     in_mode;
   logic                         in_first;
   logic                         in_last;
   logic signed [DATA_WIDTH-1:0] a_in   [ROWS][COLS];
   logic signed [DATA_WIDTH-1:0] b_in   [ROWS][COLS];
   logic signed [ACC_WIDTH-1:0]  acc_in [ROWS][COLS];

   logic                         out_valid;
   logic                         out_ready;
   logic signed [ACC_WIDTH-1:0]  result_out [ROWS][COLS];
   logic                         sat_out;
   logic [CNT_WIDTH-1:0]         burst_cnt;

   modport slave (
      input  in_valid, in_mode, in_first, in_last, a_in, b_in, acc_in, out_ready,
      output in_ready, out_valid, result_out, sat_out, burst_cnt
   );

   modport master (
      output in_valid, in_mode, in_first, in_last, a_in, b_in, acc_in, out_ready,
      input  in_ready, out_valid, result_out, sat_out, burst_cnt
   );
endinterface

// File: rtl/pe_array_acc_cell.sv
// One array element: S1 operand products, S2 saturating accumulator and result copy.
module pe_array_acc_cell
   import pe_array_acc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int FRAC_BITS  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s1_ld,
   input  logic                         s2_en,
   input  logic                         res_ld,
   input  pe_mode_e                     mode_p1,
   input  base_sel_e                    base_sel,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic signed [ACC_WIDTH-1:0]  acc_in,
   output logic signed [ACC_WIDTH-1:0]  result,
   output logic                         ovf
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0]         prod_p1;
   logic signed [DATA_WIDTH:0]   sum_p1;
   logic signed [ACC_WIDTH-1:0]  accin_p1;
   logic signed [ACC_WIDTH-1:0]  acc_p2;
   logic signed [ACC_WIDTH-1:0]  acc_nxt;
   logic signed [ACC_WIDTH-1:0]  base;
   logic signed [SAT_W-1:0]      wide;

   // S1: operand products
   always_ff @(posedge clk) begin
      if (s1_ld) begin
         prod_p1  <= PW'(a) * PW'(b);
         sum_p1   <= (DATA_WIDTH+1)'(a) + (DATA_WIDTH+1)'(b);
         accin_p1 <= acc_in;
      end
   end

   // S2: accumulate and clamp
   always_comb begin
      base = '0;
      case (base_sel)
         BASE_ACC: base = acc_p2;
         BASE_IN:  base = accin_p1;
         default:  base = '0;
      endcase
   end

   always_comb begin
      wide = '0;
      ovf  = 1'b0;
      unique case (mode_p1)
         MODE_MUL:  wide = SAT_W'(prod_p1 >>> FRAC_BITS);
         MODE_ADD:  wide = SAT_W'(sum_p1);
         MODE_MAC:  wide = SAT_W'(base) + SAT_W'(prod_p1 >>> FRAC_BITS);
         MODE_BIAS: wide = SAT_W'(accin_p1);
      endcase
      acc_nxt = ACC_WIDTH'(sat_acc(wide, ACC_WIDTH, ovf));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p2 <= '0;
         result <= '0;
      end else begin
         if (s2_en)  acc_p2 <= acc_nxt;
         if (res_ld) result <= acc_nxt;
      end
   end
endmodule

// File: rtl/pe_array_acc.sv
// ROWS x COLS element-wise PE array with multi-beat MAC bursts, burst framing FSM,
// held result register with backpressure, saturation and sticky framing-error flags.
module pe_array_acc
   import pe_array_acc_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int FRAC_BITS  = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic          clk,
   input  logic          rst,
   pe_array_acc_if.slave bus,
   output logic          err,
   input  logic          err_clr
);
   burst_state_e state_q, state_nxt;
   pe_mode_e     mode_p1;
   base_sel_e    base_sel;
   logic         vld_p1, first_p1, last_p1;
   logic         stall, s1_ld, s2_fire, res_ld;
   logic         frame_err, burst_start, any_ovf, sat_q, sat_nxt;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_nxt;
   logic [ROWS*COLS-1:0]        ovf_vec;
   logic signed [ACC_WIDTH-1:0] res_arr [ROWS][COLS];

   // A last beat may only leave S1 once the output register is free.
   assign stall        = vld_p1 && last_p1 && bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !stall;
   assign s1_ld        = bus.in_valid && !stall;
   assign s2_fire      = vld_p1 && !stall;
   assign res_ld       = s2_fire && last_p1;
   assign any_ovf      = |ovf_vec;
   assign bus.result_out = res_arr;

   // S1: beat control
   always_ff @(posedge clk) begin
      if (s1_ld) begin
         mode_p1  <= bus.in_mode;
         first_p1 <= bus.in_first;
         last_p1  <= bus.in_last || (bus.in_mode != MODE_MAC);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)          state_q <= IDLE;
      else if (s2_fire) state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      frame_err   = 1'b0;
      burst_start = 1'b1;
      base_sel    = BASE_ZERO;
      if (mode_p1 == MODE_MAC) begin
         state_nxt = last_p1 ? IDLE : ACCUM;
         if (state_q == ACCUM && !first_p1) begin
            burst_start = 1'b0;
            base_sel    = BASE_ACC;
         end else if (first_p1) begin
            base_sel  = BASE_IN;
            frame_err = (state_q == ACCUM);
         end else begin
            frame_err = 1'b1;
         end
      end else begin
         state_nxt = IDLE;
         frame_err = (state_q == ACCUM);
      end
      cnt_nxt = burst_start ? CNT_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1));
      sat_nxt = (burst_start ? 1'b0 : sat_q) | any_ovf;
   end

   // S2: burst bookkeeping and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1        <= 1'b0;
         cnt_q         <= '0;
         sat_q         <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.sat_out   <= 1'b0;
         bus.burst_cnt <= '0;
         err           <= 1'b0;
      end else begin
         if (!stall) vld_p1 <= bus.in_valid;
         if (s2_fire) begin
            cnt_q <= cnt_nxt;
            sat_q <= sat_nxt;
         end
         if (res_ld) begin
            bus.out_valid <= 1'b1;
            bus.sat_out   <= sat_nxt;
            bus.burst_cnt <= cnt_nxt;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (s2_fire && frame_err) err <= 1'b1;
         else if (err_clr)         err <= 1'b0;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         pe_array_acc_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
         ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .s1_ld    (s1_ld),
            .s2_en    (s2_fire),
            .res_ld   (res_ld),
            .mode_p1  (mode_p1),
            .base_sel (base_sel),
            .a        (bus.a_in[r][c]),
            .b        (bus.b_in[r][c]),
            .acc_in   (bus.acc_in[r][c]),
            .result   (res_arr[r][c]),
            .ovf      (ovf_vec[r*COLS+c])
         );
      end
   end
endmodule
